// File: rtl/watch_time_core.sv
// -----------------------------------------------------------------------------
// watch_time_core
//   Running hh:mm:ss.cc watch with a button-driven set mode. It is the time
//   source for the FND display controller.
//
//   Optional feature: define WATCH_SET_TIMEOUT_EN to leave set mode
//   automatically after TIMEOUT_TICKS ticks without a button pulse.
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   i_btn_set   in   one-cycle pulse, advances RUN->HOUR->MIN->SEC->RUN
//   i_btn_up    in   one-cycle pulse, increments the selected field
//   i_btn_down  in   one-cycle pulse, decrements the selected field
//   o_w_time    out  [23:19] hour, [18:13] min, [12:7] sec, [6:0] centisec
//   o_w_state   out  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   o_tick      out  registered strobe, one cycle after each divider terminal
// -----------------------------------------------------------------------------
module watch_time_core #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int TICK_HZ       = 100,
  parameter int INIT_HOUR     = 12,
  parameter int INIT_MIN      = 0,
  parameter int TIMEOUT_TICKS = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_btn_set,
  input  logic        i_btn_up,
  input  logic        i_btn_down,
  output logic [23:0] o_w_time,
  output logic [1:0]  o_w_state,
  output logic        o_tick
);

  localparam int DIV_TC = CLK_FREQ / TICK_HZ - 1;
  localparam int DIV_W  = (DIV_TC < 1) ? 1 : $clog2(DIV_TC + 1);
  localparam logic [DIV_W-1:0] DIV_TC_V = DIV_W'(DIV_TC);
  localparam logic [4:0] INIT_H = 5'(INIT_HOUR);
  localparam logic [5:0] INIT_M = 6'(INIT_MIN);

  // Elaboration-time parameter sanity checks.
  if (INIT_HOUR < 0 || INIT_HOUR > 23) begin : g_bad_hour
    $error("INIT_HOUR must be 0..23");
  end
  if (INIT_MIN < 0 || INIT_MIN > 59) begin : g_bad_min
    $error("INIT_MIN must be 0..59");
  end
  if (DIV_TC < 0) begin : g_bad_div
    $error("CLK_FREQ must be >= TICK_HZ");
  end
  if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
    $error("TIMEOUT_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOUR = 2'b01,
    ST_MIN  = 2'b10,
    ST_SEC  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [6:0]       cs_q, cs_d;
  logic             tc;
  logic             edit_up;
  logic             edit_dn;

`ifdef WATCH_SET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_TICKS);
  logic [TO_W-1:0] to_q, to_d;
`endif

  always_comb begin
    tc      = (div_q == DIV_TC_V);
    div_d   = tc ? '0 : div_q + 1'b1;
    tick_d  = tc;
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    cs_d    = cs_q;
    // Set has priority over edits; up together with down cancels out.
    edit_up = i_btn_up & ~i_btn_down & ~i_btn_set;
    edit_dn = i_btn_down & ~i_btn_up & ~i_btn_set;

    if (i_btn_set) begin
      unique case (state_q)
        ST_RUN: begin
          state_d = ST_HOUR;
          cs_d    = 7'd0;
        end
        ST_HOUR: state_d = ST_MIN;
        ST_MIN:  state_d = ST_SEC;
        ST_SEC: begin
          state_d = ST_RUN;
          // Restart the divider so the first running tick is a full period away.
          div_d   = '0;
        end
      endcase
    end else if (state_q == ST_RUN) begin
      if (tc) begin
        // Full carry chain resolved in one update.
        if (cs_q == 7'd99) begin
          cs_d = 7'd0;
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d  = 6'd0;
              hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          cs_d = cs_q + 7'd1;
        end
      end
    end else begin
      // Set states: edit only the selected field, wrap without carry.
      unique case (state_q)
        ST_HOUR: begin
          if (edit_up) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          if (edit_dn) hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
        end
        ST_MIN: begin
          if (edit_up) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          if (edit_dn) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        end
        ST_SEC: begin
          if (edit_up) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          if (edit_dn) sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
        end
        default: ;
      endcase
    end

`ifdef WATCH_SET_TIMEOUT_EN
    // Counter is held at zero in RUN and restarted by any button activity.
    to_d = to_q;
    if (state_q == ST_RUN || i_btn_set || i_btn_up || i_btn_down) begin
      to_d = '0;
    end else if (to_q == TO_LIMIT) begin
      state_d = ST_RUN;
      div_d   = '0;
      to_d    = '0;
    end else if (tc) begin
      to_d = to_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      div_q   <= '0;
      tick_q  <= 1'b0;
      hour_q  <= INIT_H;
      min_q   <= INIT_M;
      sec_q   <= 6'd0;
      cs_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      cs_q    <= cs_d;
    end
  end

`ifdef WATCH_SET_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  assign o_w_time  = {hour_q, min_q, sec_q, cs_q};
  assign o_w_state = state_q;
  assign o_tick    = tick_q;

endmodule

// File: tb/tb_watch_time_core.sv
// -----------------------------------------------------------------------------
// tb_watch_time_core
//   Self-checking bench for watch_time_core at 10 clocks per tick.
//   Button presses push the expected {time,state} to a queue; the observed
//   output one cycle later goes to a second queue and each scenario task
//   drains and compares both.
// -----------------------------------------------------------------------------
module tb_watch_time_core;

  localparam int CLK_FREQ      = 1000;
  localparam int TICK_HZ       = 100;
  localparam int TIMEOUT_TICKS = 5;

  typedef struct packed {
    logic [23:0] t;
    logic [1:0]  s;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        btn_set = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_dn = 1'b0;
  logic [23:0] w_time;
  logic [1:0]  w_state;
  logic        tick;

  int n_cmp = 0;
  int n_err = 0;

  snap_t exp_q[$];
  snap_t obs_q[$];

  always #5 clk = ~clk;

  watch_time_core #(
    .CLK_FREQ(CLK_FREQ),
    .TICK_HZ(TICK_HZ),
    .INIT_HOUR(12),
    .INIT_MIN(0),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_btn_set(btn_set),
    .i_btn_up(btn_up),
    .i_btn_down(btn_dn),
    .o_w_time(w_time),
    .o_w_state(w_state),
    .o_tick(tick)
  );

  function automatic logic [23:0] tw(input int h, input int m, input int s, input int c);
    logic [31:0] hv, mv, sv, cv;
    hv = h; mv = m; sv = s; cv = c;
    return {hv[4:0], mv[5:0], sv[5:0], cv[6:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    btn_set = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One-cycle button pulse; expectation pushed at drive time, output
  // captured at the following falling edge.
  task automatic press(input logic s, input logic u, input logic d,
                       input logic [23:0] et, input logic [1:0] es);
    snap_t e;
    snap_t o;
    @(negedge clk);
    btn_set = s; btn_up = u; btn_dn = d;
    e.t = et; e.s = es;
    exp_q.push_back(e);
    @(negedge clk);
    btn_set = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
    o.t = w_time; o.s = w_state;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    // No clock edge has occurred yet: values come from the async reset.
    n_cmp++;
    if (w_time !== tw(12, 0, 0, 0) || w_state !== 2'b00 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: got time=%h state=%b tick=%b, want time=%h state=00 tick=0",
               w_time, w_state, tick, tw(12, 0, 0, 0));
    end
    @(negedge clk);
    n_cmp++;
    if (w_time !== tw(12, 0, 0, 0) || w_state !== 2'b00 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held: got time=%h state=%b tick=%b, want time=%h state=00 tick=0",
               w_time, w_state, tick, tw(12, 0, 0, 0));
    end
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_run();
    int bad_ticks;
    do_reset();
    bad_ticks = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tick !== ((c % 10) == 0)) begin
        n_err++;
        bad_ticks++;
        if (bad_ticks < 5)
          $display("FAIL run_tick c=%0d: got %b want %b", c, tick, (c % 10) == 0);
      end
      if (c == 10) begin
        n_cmp++;
        if (w_time !== tw(12, 0, 0, 1)) begin
          n_err++;
          $display("FAIL run_first: got %h want %h", w_time, tw(12, 0, 0, 1));
        end
      end
    end
    n_cmp++;
    if (w_time !== tw(12, 0, 1, 0) || w_state !== 2'b00) begin
      n_err++;
      $display("FAIL run_100: got time=%h state=%b want time=%h state=00",
               w_time, w_state, tw(12, 0, 1, 0));
    end
    $display("test_run done: 100 ticks");
  endtask

  task automatic test_set_walk();
    snap_t e;
    snap_t o;
    do_reset();
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b01);
    press(1'b0, 1'b0, 1'b1, tw(11, 0, 0, 0), 2'b01);
    press(1'b0, 1'b0, 1'b1, tw(10, 0, 0, 0), 2'b01);
    press(1'b1, 1'b0, 1'b0, tw(10, 0, 0, 0), 2'b10);
    press(1'b0, 1'b0, 1'b1, tw(10, 59, 0, 0), 2'b10);
    press(1'b0, 1'b1, 1'b0, tw(10, 0, 0, 0), 2'b10);
    press(1'b1, 1'b0, 1'b0, tw(10, 0, 0, 0), 2'b11);
    press(1'b1, 1'b0, 1'b0, tw(10, 0, 0, 0), 2'b00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL set_walk: got time=%h state=%b, want time=%h state=%b", o.t, o.s, e.t, e.s);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        n_cmp++;
        if (w_time !== tw(10, 0, 0, 0)) begin
          n_err++;
          $display("FAIL resume_early: got %h want %h", w_time, tw(10, 0, 0, 0));
        end
      end
      if (k == 10) begin
        n_cmp++;
        if (w_time !== tw(10, 0, 0, 1) || tick !== 1'b1) begin
          n_err++;
          $display("FAIL resume_10: got time=%h tick=%b want time=%h tick=1",
                   w_time, tick, tw(10, 0, 0, 1));
        end
      end
    end
    $display("test_set_walk done");
  endtask

  task automatic test_wrap();
    snap_t e;
    snap_t o;
    do_reset();
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b01);
    for (int i = 1; i <= 12; i++)
      press(1'b0, 1'b1, 1'b0, tw((12 + i) % 24, 0, 0, 0), 2'b01);
    press(1'b0, 1'b0, 1'b1, tw(23, 0, 0, 0), 2'b01);
    press(1'b1, 1'b0, 1'b0, tw(23, 0, 0, 0), 2'b10);
    for (int i = 1; i <= 5; i++)
      press(1'b0, 1'b1, 1'b0, tw(23, i, 0, 0), 2'b10);
    press(1'b1, 1'b0, 1'b0, tw(23, 5, 0, 0), 2'b11);
    press(1'b0, 1'b0, 1'b1, tw(23, 5, 59, 0), 2'b11);
    press(1'b0, 1'b1, 1'b0, tw(23, 5, 0, 0), 2'b11);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL wrap: got time=%h state=%b, want time=%h state=%b", o.t, o.s, e.t, e.s);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_rollover();
    snap_t e;
    snap_t o;
    do_reset();
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b01);
    for (int i = 1; i <= 11; i++)
      press(1'b0, 1'b1, 1'b0, tw(12 + i, 0, 0, 0), 2'b01);
    press(1'b1, 1'b0, 1'b0, tw(23, 0, 0, 0), 2'b10);
    press(1'b0, 1'b0, 1'b1, tw(23, 59, 0, 0), 2'b10);
    press(1'b1, 1'b0, 1'b0, tw(23, 59, 0, 0), 2'b11);
    press(1'b0, 1'b0, 1'b1, tw(23, 59, 59, 0), 2'b11);
    press(1'b1, 1'b0, 1'b0, tw(23, 59, 59, 0), 2'b00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL roll_setup: got time=%h state=%b, want time=%h state=%b", o.t, o.s, e.t, e.s);
      end
    end
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 10 || k == 990 || k == 1000) begin
        e.s = 2'b00;
        e.t = (k == 10) ? tw(23, 59, 59, 1) : (k == 990) ? tw(23, 59, 59, 99) : 24'h000000;
        n_cmp++;
        if (w_time !== e.t || w_state !== e.s) begin
          n_err++;
          $display("FAIL rollover k=%0d: got time=%h state=%b want time=%h state=00",
                   k, w_time, w_state, e.t);
        end
      end
    end
    $display("test_rollover done");
  endtask

  task automatic test_collisions();
    snap_t e;
    snap_t o;
    do_reset();
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b01);
    press(1'b1, 1'b1, 1'b0, tw(12, 0, 0, 0), 2'b10);
    press(1'b0, 1'b1, 1'b1, tw(12, 0, 0, 0), 2'b10);
    press(1'b1, 1'b0, 1'b1, tw(12, 0, 0, 0), 2'b11);
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b00);
    press(1'b0, 1'b1, 1'b0, tw(12, 0, 0, 0), 2'b00);
    press(1'b0, 1'b0, 1'b1, tw(12, 0, 0, 0), 2'b00);
    // Reset in the middle of a set sequence loses the edits.
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b01);
    press(1'b0, 1'b1, 1'b0, tw(13, 0, 0, 0), 2'b01);
    press(1'b1, 1'b0, 1'b0, tw(13, 0, 0, 0), 2'b10);
    press(1'b0, 1'b0, 1'b1, tw(13, 59, 0, 0), 2'b10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL collide: got time=%h state=%b, want time=%h state=%b", o.t, o.s, e.t, e.s);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (w_time !== tw(12, 0, 0, 0) || w_state !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid_set: got time=%h state=%b want time=%h state=00",
               w_time, w_state, tw(12, 0, 0, 0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("test_collisions done");
  endtask

`ifdef WATCH_SET_TIMEOUT_EN
  task automatic test_timeout();
    snap_t e;
    snap_t o;
    int ticks;
    logic exited;
    do_reset();
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b01);
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b10);
    press(1'b0, 1'b1, 1'b0, tw(12, 1, 0, 0), 2'b10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL to_setup: got time=%h state=%b, want time=%h state=%b", o.t, o.s, e.t, e.s);
      end
    end
    ticks = 0; exited = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (w_state == 2'b00) begin exited = 1'b1; break; end
      if (tick) ticks++;
    end
    n_cmp++;
    if (exited !== 1'b1 || ticks != TIMEOUT_TICKS || w_time !== tw(12, 1, 0, 0)) begin
      n_err++;
      $display("FAIL timeout: got exited=%b ticks=%0d time=%h want exited=1 ticks=%0d time=%h",
               exited, ticks, w_time, TIMEOUT_TICKS, tw(12, 1, 0, 0));
    end
    // A pulse after the 4th tick restarts the count.
    do_reset();
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b01);
    press(1'b1, 1'b0, 1'b0, tw(12, 0, 0, 0), 2'b10);
    ticks = 0;
    for (int c = 0; c < 300 && ticks < 4 && w_state != 2'b00; c++) begin
      @(negedge clk);
      if (tick && w_state != 2'b00) ticks++;
    end
    press(1'b0, 1'b1, 1'b0, tw(12, 1, 0, 0), 2'b10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL to_restart_setup: got time=%h state=%b, want time=%h state=%b", o.t, o.s, e.t, e.s);
      end
    end
    ticks = 0; exited = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (w_state == 2'b00) begin exited = 1'b1; break; end
      if (tick) ticks++;
    end
    n_cmp++;
    if (exited !== 1'b1 || ticks != TIMEOUT_TICKS) begin
      n_err++;
      $display("FAIL timeout_restart: got exited=%b ticks=%0d want exited=1 ticks=%0d",
               exited, ticks, TIMEOUT_TICKS);
    end
    $display("test_timeout done");
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run();
    test_set_walk();
    test_wrap();
    test_rollover();
    test_collisions();
`ifdef WATCH_SET_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
